uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_tx_serializer.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// Byte-queue UART transmitter: a small FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_tx_data,
  input  logic       uart_tx_valid,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic [4:0] fifo_count,
  output logic       overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]         count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic       fifo_empty;
  logic       full;
  logic       bit_done;
  logic       pop;
  logic       push;
  logic [7:0] head;

  assign fifo_empty = (count_q == 5'd0);
  assign full       = (count_q == 5'(FIFO_DEPTH));
  assign bit_done   = (baud_q == 16'(CLKS_PER_BIT - 1));
  assign head       = mem[rd_ptr_q];
  // A full queue can still take a byte on the cycle the serializer frees a slot.
  assign push       = uart_tx_valid && (!full || pop);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames stay contiguous.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    parity_d = parity_q;
    if (pop) parity_d = ^head;
  end
`endif

  // The line is registered from the next state so it changes on the same edge
  // as the FSM and never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    ovf_d = uart_tx_valid && !push;
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // NOTE: the byte storage has no reset; clearing the pointers and count
  // already makes stale contents unreachable, and it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= uart_tx_data;
  end

  assign tx_serial  = tx_q;
  assign tx_busy    = (state_q != IDLE) || !fifo_empty;
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed line values.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       tx_serial, tx_busy, fifo_full, overflow;
  logic [4:0] fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .uart_tx_data(data), .uart_tx_valid(valid),
    .tx_serial(tx_serial), .tx_busy(tx_busy),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the frame currently on the line,
  // expressed as a bit list and the number of cycles spent in it.
  logic [7:0]  mq[$];
  logic [10:0] m_bits = '1;
  int          m_t = 0;
  bit          m_act = 1'b0;
  bit          m_ovf = 1'b0;

  initial begin
    bit         pop, acc;
    logic [7:0] fb;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_act = 1'b0;
        m_t   = 0;
        m_ovf = 1'b0;
      end else begin
        pop = (mq.size() > 0) && (!m_act || m_t == FL - 1);
        acc = valid && ((mq.size() < D) || pop);
        if (pop) begin
          fb = mq.pop_front();
`ifdef UART_TX_PARITY_EN
          m_bits = {1'b1, ^fb, fb, 1'b0};
`else
          m_bits = {2'b11, fb, 1'b0};
`endif
          m_act = 1'b1;
          m_t   = 0;
        end else if (m_act) begin
          if (m_t == FL - 1) m_act = 1'b0;
          else m_t++;
        end
        if (acc) mq.push_back(data);
        m_ovf = valid && !acc;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("tx_serial",  tx_serial,  m_act ? m_bits[m_t / C] : 1'b1);
      check("tx_busy",    tx_busy,    m_act || (mq.size() != 0));
      check("fifo_count", fifo_count, mq.size());
      check("fifo_full",  fifo_full,  mq.size() == D);
      check("overflow",   overflow,   m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    valid = 1'b0;
    while (tx_busy && k < 8 * FL) begin
      tick();
      k++;
    end
    check("drain_idle", tx_busy, 1'b0);
    repeat (3) tick();
  endtask

  // Line for 0xA5: start, 1,0,1,0,0,1,0,1, (parity 0), stop.
`ifdef UART_TX_PARITY_EN
  int a5_line[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
  int a5_line[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_tx",    tx_serial,  1'b1);
    check("rst_count", fifo_count, 5'd0);
    tick();

    // Single 0xA5 frame: low from cycle 2, busy drops after the stop bit.
    for (int c = 0; c <= FL + 2; c++) begin
      valid = (c == 0);
      data  = 8'hA5;
      @(negedge clk);
      if (c == 1) check("a5_pre_start", tx_serial, 1'b1);
      if (c >= 2 && c < 2 + FL && ((c - 2) % C) == 0)
        check("a5_bit", tx_serial, a5_line[(c - 2) / C]);
      if (c == 1 + FL) check("a5_busy_hi", tx_busy, 1'b1);
      if (c == 2 + FL) check("a5_busy_lo", tx_busy, 1'b0);
      tick();
    end
    drain();

    // Three back-to-back bytes: each stop bit runs straight into a start bit.
    for (int c = 0; c <= 2 + 3 * FL; c++) begin
      valid = (c < 3);
      data  = 8'(c + 1);
      @(negedge clk);
      if (c == 1 + FL)     check("b2b_stop1",  tx_serial, 1'b1);
      if (c == 2 + FL)     check("b2b_start2", tx_serial, 1'b0);
      if (c == 1 + 2 * FL) check("b2b_stop2",  tx_serial, 1'b1);
      if (c == 2 + 2 * FL) check("b2b_start3", tx_serial, 1'b0);
      if (c == 1 + 3 * FL) check("b2b_busy_hi", tx_busy, 1'b1);
      if (c == 2 + 3 * FL) check("b2b_busy_lo", tx_busy, 1'b0);
      tick();
    end
    drain();

    // Six pushes fill the queue and drop one; a push on the pop edge fits.
    for (int c = 0; c <= FL + 3; c++) begin
      valid = (c < 6) || (c == FL + 1);
      data  = 8'h10 + 8'(c);
      @(negedge clk);
      if (c == 5) begin
        check("ovf_full",   fifo_full,  1'b1);
        check("ovf_count4", fifo_count, 5'd4);
      end
      if (c == 6) begin
        check("ovf_pulse",  overflow,   1'b1);
        check("ovf_count",  fifo_count, 5'd4);
      end
      if (c == 7)      check("ovf_single", overflow, 1'b0);
      if (c == FL + 1) check("pp_full",    fifo_full, 1'b1);
      if (c == FL + 2) begin
        check("pp_no_ovf", overflow,   1'b0);
        check("pp_count",  fifo_count, 5'd4);
      end
      tick();
    end
    drain();

    // Reset in the middle of data bit 3 of 0x30 (bit 3 = 0), two bytes queued.
    for (int c = 0; c < 19; c++) begin
      valid = (c < 3);
      data  = 8'h30 + 8'(c);
      tick();
    end
    valid = 1'b1;
    #1;
    check("mid_bit3", tx_serial, 1'b0);
    check("mid_qcnt", fifo_count, 5'd2);
    rst = 1'b1;
    #1;
    check("rst_mid_tx",    tx_serial,  1'b1);
    check("rst_mid_count", fifo_count, 5'd0);
    check("rst_mid_busy",  tx_busy,    1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b0;
    repeat (2 * FL) tick();
    check("post_rst_tx",   tx_serial, 1'b1);
    check("post_rst_busy", tx_busy,   1'b0);

`ifdef UART_TX_PARITY_EN
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c <= 2 + 9 * C; c++) begin
        valid = (c == 0);
        data  = (p == 0) ? 8'h07 : 8'h03;
        @(negedge clk);
        if (c == 2 + 9 * C) check("parity_bit", tx_serial, (p == 0) ? 1'b1 : 1'b0);
        tick();
      end
      drain();
    end
`endif

    // Randomized traffic at several push densities, with rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      int rate = (blk % 4 == 0) ? 3 : (blk % 4 == 1) ? 20 : (blk % 4 == 2) ? 60 : 95;
      for (int c = 0; c < 500; c++) begin
        valid = ($urandom_range(0, 99) < rate);
        data  = 8'($urandom);
        if ($urandom_range(0, 999) == 0) begin
          rst = 1'b1;
          tick();
          tick();
          rst = 1'b0;
        end
        tick();
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
